// File: rtl/entry_pkg.sv
// entry_pkg: shared types and width helpers for the entry sequencer.
//   state_t    : controller state (ENTRY / CONVERT / SHOW)
//   NIBBLE_W   : bits per hex digit
//   COUNT_W    : width of the digit counter (holds 0..8)
//   cnt_w()    : counter width able to hold the values 0..n-1
//   operand_w(): operand width for a given number of digits
package entry_pkg;

  localparam int NIBBLE_W = 4;
  localparam int COUNT_W  = 4;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int operand_w(input int digits);
    return NIBBLE_W * digits;
  endfunction

endpackage

// File: rtl/entry_sequencer_button_debounce.sv
// button_debounce: conditions one raw push button.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw, bouncy, asynchronous button level (active-high)
//   press : one-cycle pulse on each accepted 0->1 change of the debounced level
// The debounced level only follows the synchronised input once it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle
// restarts the count.
module button_debounce
  import entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      // stage p0/p1: two-flop synchroniser
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // stable-count filter on the synchronised level
      level_d <= level;
      if (sync_p1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/entry_sequencer.sv
// entry_sequencer: front-end controller between buttons/switches and the
// IEEE754 conversion/display datapath.
//   clk100mhz   : system clock
//   reset       : asynchronous active-low reset
//   switches    : hex digit to enter (asynchronous)
//   enter       : raw button, appends the switch digit to the operand
//   confirm     : raw button, launches a conversion once all digits are in
//   conv_done   : one-cycle pulse from the converter
//   operand     : assembled value, first digit most significant
//   digit_count : digits entered so far (0..DIGITS)
//   conv_start  : one-cycle launch pulse
//   show_result : 1 = display converter result, 0 = display entry buffer
//   busy        : waiting for conv_done
//   conv_error  : sticky timeout flag
module entry_sequencer
  import entry_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk100mhz,
  input  logic                       reset,
  input  logic [3:0]                 switches,
  input  logic                       enter,
  input  logic                       confirm,
  input  logic                       conv_done,
  output logic [NIBBLE_W*DIGITS-1:0] operand,
  output logic [COUNT_W-1:0]         digit_count,
  output logic                       conv_start,
  output logic                       show_result,
  output logic                       busy,
  output logic                       conv_error
);

  localparam int OP_W = operand_w(DIGITS);
  localparam int TO_W = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] FULL    = COUNT_W'(DIGITS);

  logic [3:0]         sw_p0;
  logic [3:0]         sw_p1;
  logic               enter_evt;
  logic               confirm_evt;
  state_t             state;
  state_t             state_next;
  logic [OP_W-1:0]    operand_next;
  logic [COUNT_W-1:0] count_next;
  logic               start_next;
  logic               busy_next;
  logic               show_next;
  logic               error_next;
  logic [TO_W-1:0]    tcnt;
  logic [TO_W-1:0]    tcnt_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk100mhz),
    .rst_n (reset),
    .btn   (enter),
    .press (enter_evt)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clk   (clk100mhz),
    .rst_n (reset),
    .btn   (confirm),
    .press (confirm_evt)
  );

  always_comb begin
    state_next   = state;
    operand_next = operand;
    count_next   = digit_count;
    start_next   = 1'b0;
    busy_next    = busy;
    show_next    = show_result;
    error_next   = conv_error;
    tcnt_next    = tcnt;
    case (state)
      ENTRY: begin
        // confirm outranks enter only when the operand is complete
        if (confirm_evt && (digit_count == FULL)) begin
          state_next = CONVERT;
          start_next = 1'b1;
          busy_next  = 1'b1;
          tcnt_next  = '0;
        end else if (enter_evt && (digit_count < FULL)) begin
          operand_next = {operand[OP_W-NIBBLE_W-1:0], sw_p1};
          count_next   = digit_count + COUNT_W'(1);
          error_next   = 1'b0;
        end
      end
      CONVERT: begin
        // button events are dropped here; a done pulse wins over timeout
        if (conv_done) begin
          state_next = SHOW;
          busy_next  = 1'b0;
          show_next  = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_next = ENTRY;
          busy_next  = 1'b0;
          error_next = 1'b1;
        end else begin
          tcnt_next = tcnt + TO_W'(1);
        end
      end
      SHOW: begin
        // enter starts a fresh operand; the press itself stores no digit
        if (enter_evt) begin
          state_next   = ENTRY;
          operand_next = '0;
          count_next   = '0;
          show_next    = 1'b0;
          error_next   = 1'b0;
        end else if (confirm_evt) begin
          state_next = CONVERT;
          start_next = 1'b1;
          busy_next  = 1'b1;
          tcnt_next  = '0;
        end
      end
      default: state_next = ENTRY;
    endcase
  end

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      sw_p0       <= '0;
      sw_p1       <= '0;
      state       <= ENTRY;
      operand     <= '0;
      digit_count <= '0;
      conv_start  <= 1'b0;
      busy        <= 1'b0;
      show_result <= 1'b0;
      conv_error  <= 1'b0;
      tcnt        <= '0;
    end else begin
      // stage p0/p1: switch synchroniser
      sw_p0       <= switches;
      sw_p1       <= sw_p0;
      // controller state
      state       <= state_next;
      operand     <= operand_next;
      digit_count <= count_next;
      conv_start  <= start_next;
      busy        <= busy_next;
      show_result <= show_next;
      conv_error  <= error_next;
      tcnt        <= tcnt_next;
    end
  end

endmodule

// File: doc/entry_sequencer.md
Name: entry_sequencer

Overview:
- Front-end controller between the board buttons/switches and the IEEE754 conversion/display datapath.
- Collects DIGITS hex nibbles from switches on debounced enter presses and assembles them into an operand.
- On a debounced confirm it launches one conversion and waits for completion, with a timeout.
- Tells the display path whether to show the entry buffer or the result.

Parameters:
- DIGITS, 4, number of hex nibbles per operand (2..8)
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a button level is accepted (10 ms at 100 MHz); bench overrides to 4
- TIMEOUT_CYCLES, 1024, max cycles to wait for conv_done after conv_start

Ports:
- clk100mhz  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- switches  in  4  hex digit to enter, asynchronous to clock
- enter  in  1  raw push button, active-high, bouncy
- confirm  in  1  raw push button, active-high, bouncy
- conv_done  in  1  one-cycle pulse from converter, result valid
- operand  out  4*DIGITS  assembled value; first-entered nibble ends up most significant
- digit_count  out  4  nibbles entered, 0..DIGITS
- conv_start  out  1  one-cycle pulse launching conversion of operand
- show_result  out  1  1 = display converter result, 0 = display entry buffer
- busy  out  1  high while waiting for conv_done
- conv_error  out  1  sticky; set on timeout, cleared by next accepted enter or reset

Behaviour:
- Reset (reset=0, async): all outputs 0, state ENTRY, synchronisers and debounce counters 0.
- Input conditioning:
  - enter, confirm and switches each pass a 2-flop synchroniser.
  - enter and confirm each feed a debouncer. The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch restarts that counter.
  - A press is a 0->1 transition of the debounced level: exactly one event per physical press, however long it is held.
- Press latency: a raw press stable from sampling edge k produces its event at edge k+2+DEBOUNCE_CYCLES. The resulting register update is visible one cycle later.
- ENTRY state:
  - enter event with digit_count<DIGITS: operand <= {operand[4*DIGITS-5:0], switches_sync}, digit_count+1, conv_error <= 0.
  - enter event with digit_count==DIGITS: ignored, no change.
  - confirm event with digit_count==DIGITS: go CONVERT.
  - confirm event with digit_count<DIGITS: ignored.
  - enter and confirm events on the same cycle: confirm wins if digit_count==DIGITS; otherwise enter is taken.
- CONVERT state:
  - conv_start is high for exactly the first cycle in CONVERT. busy is 1 throughout; a timeout counter runs.
  - conv_done: go SHOW, busy <= 0, show_result <= 1.
  - Timeout counter reaches TIMEOUT_CYCLES with no conv_done: conv_error <= 1, busy <= 0, return to ENTRY. operand and digit_count are kept.
  - conv_done in the same cycle as conv_start is accepted.
  - Button events are discarded while in CONVERT.
- SHOW state:
  - enter event: operand <= 0, digit_count <= 0, show_result <= 0, go ENTRY. The press is consumed and no digit is stored.
  - confirm event: relaunch conversion (go CONVERT) with the same operand.
  - conv_done pulses in ENTRY or SHOW are ignored.
- Async reset mid-conversion: immediate return to the reset state; a late conv_done afterwards is ignored.

Decomposition:
- Package entry_pkg:
  - state enum ENTRY/CONVERT/SHOW, 2 bits
  - localparam widths derived from DIGITS
  - clog2-based counter widths for DEBOUNCE_CYCLES and TIMEOUT_CYCLES
- Sub-module button_debounce (synchroniser + stable-count debouncer + rising-edge pulse), parameter DEBOUNCE_CYCLES, instantiated for enter and confirm.
- Switch synchroniser stays inline.

Test Plan:
- DEBOUNCE_CYCLES=4; enter F, D, 6, C (each held 20 cycles) -> operand=16'hFD6C and digit_count=4 after the 4th press; no conv_start before confirm.
- Enter bouncing 1-0-1 at 1-cycle intervals, then held stable 20 cycles -> exactly one digit captured; a 3-cycle pulse alone -> nothing captured.
- Confirm with digit_count=2 -> no conv_start, state stays ENTRY; fifth enter after 4 digits -> operand unchanged.
- Full entry + confirm, conv_done 5 cycles after conv_start -> single 1-cycle conv_start, busy high for the wait, then show_result=1 and busy=0.
- Full entry + confirm, conv_done never sent, TIMEOUT_CYCLES=16 -> conv_error=1 after 16 cycles, state ENTRY, operand kept; next enter -> conv_error=0.
- In SHOW: press enter -> operand=0, digit_count=0, show_result=0. Separately, reset=0 while busy -> all outputs 0 immediately, and a later conv_done has no effect.
